// File: rtl/conv_encoder_tx.sv
// conv_encoder_tx
// Rate-1/2 zero-terminated convolutional encoder (K=9, 256-state trellis).
// A frame of FRAME_LEN information bits is accepted over a valid/ready
// stream and is followed by K-1 zero tail bits that drive the trellis back
// to state 0. Each encoded bit produces one {c1,c0} symbol in a registered
// output slot with valid/ready flow control.
//
// Ports:
//   Clock      rising-edge clock
//   Reset      asynchronous, active-high reset
//   Start      one-cycle pulse, begins a frame when idle
//   InValid    InBit is valid
//   InBit      information bit
//   InReady    encoder accepts InBit this cycle
//   OutValid   OutSymbol is valid
//   OutSymbol  {c1,c0} code symbol
//   OutReady   sink accepts OutSymbol this cycle
//   OutLast    marks the final tail symbol of the frame
//   Busy       frame in progress or output slot still occupied
//   EncState   encoder shift register after the most recent encode
module conv_encoder_tx #(
  parameter int             K         = 9,
  parameter logic [K-1:0]   G0        = 9'o561,
  parameter logic [K-1:0]   G1        = 9'o753,
  parameter int             FRAME_LEN = 1024,
  parameter int             CNT_W     = 16
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           Start,
  input  logic           InValid,
  input  logic           InBit,
  output logic           InReady,
  output logic           OutValid,
  output logic [1:0]     OutSymbol,
  input  logic           OutReady,
  output logic           OutLast,
  output logic           Busy,
  output logic [K-2:0]   EncState
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [K-2:0]       enc_state_q;
  logic               out_valid_q;
  logic [1:0]         out_symbol_q;
  logic               out_last_q;

  logic               slot_free;
  logic               encode;
  logic               enc_bit;
  logic               start_frame;
  logic               in_ready;
  logic               last_data;
  logic               last_tail;
  logic [K-1:0]       vec;
  logic [1:0]         symbol;

  // The output slot can take a new symbol when it is empty or being drained
  // in this very cycle.
  assign slot_free = ~out_valid_q | OutReady;

  assign last_data = (cnt_q == CNT_W'(FRAME_LEN - 1));
  assign last_tail = (cnt_q == CNT_W'(K - 2));

  // Newest bit sits at the MSB so the generator's bit K-1 taps it.
  assign vec    = {enc_bit, enc_state_q};
  assign symbol = {^(vec & G1), ^(vec & G0)};

  // Next-state and handshake decode. Start is only honoured in IDLE; the
  // tail phase ignores the input stream and encodes zeros whenever the
  // output slot frees up.
  always_comb begin
    state_d     = state_q;
    in_ready    = 1'b0;
    encode      = 1'b0;
    enc_bit     = 1'b0;
    start_frame = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          start_frame = 1'b1;
          state_d     = DATA;
        end
      end
      DATA: begin
        in_ready = slot_free;
        if (InValid && slot_free) begin
          encode  = 1'b1;
          enc_bit = InBit;
          if (last_data) begin
            state_d = TAIL;
          end
        end
      end
      TAIL: begin
        if (slot_free) begin
          encode = 1'b1;
          if (last_tail) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Bit counter: counts data bits, then restarts to count tail bits.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else if (start_frame) begin
      cnt_q <= '0;
    end else if (encode) begin
      if ((state_q == DATA && last_data) || (state_q == TAIL && last_tail)) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Encoder shift register; it only moves on an encode, so it stays put
  // while the output slot is stalled.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      enc_state_q <= '0;
    end else if (start_frame) begin
      enc_state_q <= '0;
    end else if (encode) begin
      enc_state_q <= vec[K-1:1];
    end
  end

  // Output slot. A new encode overrides a simultaneous drain so back-to-back
  // symbols flow at one per cycle; OutLast travels with its own symbol only.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      out_valid_q  <= 1'b0;
      out_symbol_q <= 2'b00;
      out_last_q   <= 1'b0;
    end else if (encode) begin
      out_valid_q  <= 1'b1;
      out_symbol_q <= symbol;
      out_last_q   <= (state_q == TAIL) && last_tail;
    end else if (OutReady) begin
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
    end
  end

  assign InReady   = in_ready;
  assign OutValid  = out_valid_q;
  assign OutSymbol = out_symbol_q;
  assign OutLast   = out_last_q;
  assign EncState  = enc_state_q;
  assign Busy      = (state_q != IDLE) | out_valid_q;

endmodule

// File: tb/tb_conv_encoder_tx.sv
// tb_conv_encoder_tx
// Self-checking bench for conv_encoder_tx with FRAME_LEN=16. Expected
// symbols come from a hand-computed impulse table and from an independent
// tap-by-tap model of the K=9 encoder.
module tb_conv_encoder_tx;

  localparam int          K     = 9;
  localparam int          FLEN  = 16;
  localparam int          NSYM  = FLEN + K - 1;
  localparam logic [8:0]  TB_G0 = 9'o561;
  localparam logic [8:0]  TB_G1 = 9'o753;

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic        InValid;
  logic        InBit;
  logic        InReady;
  logic        OutValid;
  logic [1:0]  OutSymbol;
  logic        OutReady;
  logic        OutLast;
  logic        Busy;
  logic [7:0]  EncState;

  conv_encoder_tx #(
    .K(9), .G0(9'o561), .G1(9'o753), .FRAME_LEN(FLEN), .CNT_W(16)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .InValid(InValid),
    .InBit(InBit), .InReady(InReady), .OutValid(OutValid),
    .OutSymbol(OutSymbol), .OutReady(OutReady), .OutLast(OutLast),
    .Busy(Busy), .EncState(EncState)
  );

  typedef struct {
    logic        in_bit;
    logic [1:0]  exp_sym;
    logic        exp_last;
  } vec_t;

  vec_t        tbl [NSYM];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          in_hs    = 0;
  int          bp_mode  = 0;
  logic [1:0]  got_sym  [$];
  logic        got_last [$];
  logic [1:0]  exp_sym  [$];
  logic        exp_last [$];

  logic        hold_pending = 1'b0;
  logic [1:0]  held_sym;
  logic        held_last;
  logic [7:0]  held_state;

  // Clock generation.
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Sink ready driver: always ready, random, or forced stall.
  initial begin
    OutReady = 1'b1;
    forever begin
      @(posedge Clock);
      #1;
      case (bp_mode)
        0:       OutReady = 1'b1;
        1:       OutReady = 1'($urandom_range(0, 1));
        default: OutReady = 1'b0;
      endcase
    end
  end

  // Hard stop if something hangs.
  initial begin
    #400000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Output monitor: collects handshaken symbols and checks stall stability
  // and that InReady never asserts while the output slot is blocked.
  always @(negedge Clock) begin
    if (Reset) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        checkOutput("hold_valid", int'(OutValid), 1);
        checkOutput("hold_sym", int'(OutSymbol), int'(held_sym));
        checkOutput("hold_last", int'(OutLast), int'(held_last));
        checkOutput("hold_state", int'(EncState), int'(held_state));
      end
      if (InReady) begin
        checkOutput("inready_free", int'(!OutValid || OutReady), 1);
      end
      if (OutValid && OutReady) begin
        got_sym.push_back(OutSymbol);
        got_last.push_back(OutLast);
      end
      if (InValid && InReady) begin
        in_hs++;
      end
      hold_pending = OutValid && !OutReady;
      held_sym     = OutSymbol;
      held_last    = OutLast;
      held_state   = EncState;
    end
  end

  task automatic step();
    @(posedge Clock);
    #2;
  endtask

  // Reference encoder: hist[0] is the newest bit, hist[t] meets generator
  // tap K-1-t.
  task automatic buildModel(input logic [15:0] bits, input int n);
    logic [8:0] hist;
    logic       b;
    logic       c0;
    logic       c1;
    hist = '0;
    for (int j = 0; j < n + K - 1; j++) begin
      b    = (j < n) ? bits[j] : 1'b0;
      hist = {hist[7:0], b};
      c0   = 1'b0;
      c1   = 1'b0;
      for (int t = 0; t < K; t++) begin
        c0 = c0 ^ (hist[t] & TB_G0[K-1-t]);
        c1 = c1 ^ (hist[t] & TB_G1[K-1-t]);
      end
      exp_sym.push_back({c1, c0});
      exp_last.push_back(j == n + K - 2);
    end
  endtask

  task automatic clearQueues();
    got_sym.delete();
    got_last.delete();
    exp_sym.delete();
    exp_last.delete();
    in_hs = 0;
  endtask

  // Sends n_bits of a frame; optional Start pulse first, optional random
  // InValid gaps, optional stray Start pulse in the middle of DATA.
  task automatic applyStimulus(input logic [15:0] bits, input int n_bits,
                               input bit do_start, input bit rand_valid,
                               input bit glitch_start);
    int i;
    int guard;
    bit hs;
    if (do_start) begin
      Start = 1'b1;
      step();
      Start = 1'b0;
    end
    i = 0;
    guard = 0;
    while (i < n_bits && guard < 2000) begin
      InValid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
      InBit   = InValid ? bits[i] : 1'($urandom_range(0, 1));
      Start   = glitch_start && (i == 5);
      @(negedge Clock);
      hs = InValid && InReady;
      step();
      if (hs) i++;
      guard++;
    end
    InValid = 1'b0;
    InBit   = 1'b0;
    Start   = 1'b0;
    checkOutput("send_done", i, n_bits);
  endtask

  task automatic waitSymbols(input int n);
    int guard;
    guard = 0;
    while (got_sym.size() < n && guard < 3000) begin
      @(negedge Clock);
      guard++;
    end
    for (int c = 0; c < 6; c++) step();
    checkOutput("sym_count", got_sym.size(), n);
  endtask

  task automatic compareStream(input string tag);
    int n;
    n = (got_sym.size() < exp_sym.size()) ? got_sym.size() : exp_sym.size();
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, "_sym"}, int'(got_sym[i]), int'(exp_sym[i]));
      checkOutput({tag, "_last"}, int'(got_last[i]), int'(exp_last[i]));
    end
  endtask

  task automatic checkTable();
    for (int i = 0; i < NSYM && i < got_sym.size(); i++) begin
      checkOutput("impulse_sym", int'(got_sym[i]), int'(tbl[i].exp_sym));
      checkOutput("impulse_last", int'(got_last[i]), int'(tbl[i].exp_last));
    end
  endtask

  initial begin
    logic [1:0]  imp [9];
    logic [15:0] bits;
    logic [15:0] bits_b;

    // Impulse response of the 561/753 pair, then zeros through the tail.
    imp[0] = 2'b11; imp[1] = 2'b10; imp[2] = 2'b11; imp[3] = 2'b11;
    imp[4] = 2'b01; imp[5] = 2'b10; imp[6] = 2'b00; imp[7] = 2'b10;
    imp[8] = 2'b11;
    for (int i = 0; i < NSYM; i++) begin
      tbl[i].in_bit   = (i == 0);
      tbl[i].exp_sym  = (i < 9) ? imp[i] : 2'b00;
      tbl[i].exp_last = (i == NSYM - 1);
    end

    Reset   = 1'b1;
    Start   = 1'b0;
    InValid = 1'b0;
    InBit   = 1'b0;
    step();
    step();
    Reset = 1'b0;
    step();

    // Reset state.
    @(negedge Clock);
    checkOutput("rst_outvalid", int'(OutValid), 0);
    checkOutput("rst_outsymbol", int'(OutSymbol), 0);
    checkOutput("rst_outlast", int'(OutLast), 0);
    checkOutput("rst_inready", int'(InReady), 0);
    checkOutput("rst_busy", int'(Busy), 0);
    checkOutput("rst_encstate", int'(EncState), 0);
    step();

    // Impulse frame, full throughput.
    $display("[TB] impulse frame");
    clearQueues();
    bp_mode = 0;
    bits = '0;
    for (int i = 0; i < FLEN; i++) bits[i] = tbl[i].in_bit;
    applyStimulus(bits, FLEN, 1'b1, 1'b0, 1'b0);
    waitSymbols(NSYM);
    checkTable();
    checkOutput("impulse_encstate", int'(EncState), 0);
    checkOutput("impulse_in_hs", in_hs, FLEN);
    checkOutput("impulse_busy", int'(Busy), 0);

    // All-zero frame.
    $display("[TB] all-zero frame");
    clearQueues();
    buildModel(16'h0000, FLEN);
    applyStimulus(16'h0000, FLEN, 1'b1, 1'b0, 1'b0);
    checkOutput("zero_encstate_mid", int'(EncState), 0);
    waitSymbols(NSYM);
    compareStream("zero");
    checkOutput("zero_encstate", int'(EncState), 0);
    checkOutput("zero_in_hs", in_hs, FLEN);

    // Random frame with random backpressure and input gaps.
    $display("[TB] backpressure frame");
    clearQueues();
    bp_mode = 1;
    bits = 16'($urandom);
    buildModel(bits, FLEN);
    applyStimulus(bits, FLEN, 1'b1, 1'b1, 1'b0);
    waitSymbols(NSYM);
    compareStream("bp");
    checkOutput("bp_encstate", int'(EncState), 0);

    // Stray Start pulses during DATA and TAIL must be ignored.
    $display("[TB] start glitch frame");
    clearQueues();
    bp_mode = 0;
    bits = 16'hA5C3;
    buildModel(bits, FLEN);
    applyStimulus(bits, FLEN, 1'b1, 1'b0, 1'b1);
    Start = 1'b1;
    step();
    Start = 1'b0;
    waitSymbols(NSYM);
    compareStream("glitch");
    checkOutput("glitch_busy", int'(Busy), 0);

    // Reset after five data bits, then a fresh impulse frame.
    $display("[TB] reset mid-frame");
    clearQueues();
    applyStimulus(16'h001F, 5, 1'b1, 1'b0, 1'b0);
    Reset = 1'b1;
    @(negedge Clock);
    checkOutput("midrst_outvalid", int'(OutValid), 0);
    checkOutput("midrst_busy", int'(Busy), 0);
    checkOutput("midrst_encstate", int'(EncState), 0);
    checkOutput("midrst_outlast", int'(OutLast), 0);
    step();
    Reset = 1'b0;
    step();
    clearQueues();
    bits = '0;
    for (int i = 0; i < FLEN; i++) bits[i] = tbl[i].in_bit;
    applyStimulus(bits, FLEN, 1'b1, 1'b0, 1'b0);
    waitSymbols(NSYM);
    checkTable();

    // Back-to-back frames: Start while the last symbol of frame A is stalled.
    $display("[TB] back-to-back frames");
    clearQueues();
    bp_mode = 1;
    bits   = 16'($urandom);
    bits_b = 16'($urandom);
    buildModel(bits, FLEN);
    buildModel(bits_b, FLEN);
    applyStimulus(bits, FLEN, 1'b1, 1'b0, 1'b0);
    begin
      int guard;
      guard = 0;
      while (!(OutValid && OutLast) && guard < 500) begin
        step();
        guard++;
      end
      checkOutput("b2b_last_seen", int'(OutValid && OutLast), 1);
    end
    bp_mode  = 2;
    OutReady = 1'b0;
    Start    = 1'b1;
    step();
    Start    = 1'b0;
    checkOutput("b2b_busy_pending", int'(Busy), 1);
    bp_mode  = 1;
    applyStimulus(bits_b, FLEN, 1'b0, 1'b1, 1'b0);
    waitSymbols(2 * NSYM);
    compareStream("b2b");
    begin
      int lasts;
      lasts = 0;
      foreach (got_last[i]) if (got_last[i]) lasts++;
      checkOutput("b2b_last_count", lasts, 2);
    end

    bp_mode = 0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_encoder_tx.md
Name: conv_encoder_tx

Overview:
- Rate-1/2 zero-terminated convolutional encoder; the transmit-side counterpart of the Viterbi decoder.
- Accepts a frame of FRAME_LEN information bits over a valid/ready stream, then appends K-1 zero tail bits so the trellis ends in state 0.
- Emits one 2-bit code symbol per input bit on a registered valid/ready output.
- Trellis, polynomials and state numbering match the decoder (K=9, 256 states), so the encoder state can be compared directly with the decoder's LowestState in system benches.

Parameters:
- K, 9, constraint length; state width is K-1 (=8, matches WD_STATE).
- G0, 9'o561, generator for symbol bit 0; bit K-1 taps the newest input.
- G1, 9'o753, generator for symbol bit 1.
- FRAME_LEN, 1024, information bits per frame; legal range 1..2^CNT_W-1.
- CNT_W, 16, bit counter width.

Ports:
- Clock  input  1  single rising-edge clock.
- Reset  input  1  asynchronous, active-high.
- Start  input  1  one-cycle pulse; begins a frame when idle.
- InValid  input  1  InBit is valid.
- InBit  input  1  information bit.
- InReady  output  1  encoder accepts InBit this cycle.
- OutValid  output  1  OutSymbol is valid.
- OutSymbol  output  2  {c1,c0} code symbol.
- OutReady  input  1  sink accepts OutSymbol this cycle.
- OutLast  output  1  qualifies the final tail symbol of the frame.
- Busy  output  1  frame in progress (state != IDLE, or output register still holds a symbol).
- EncState  output  K-1  encoder shift register after the most recently encoded bit.

Behaviour:
- Reset values: OutValid=0, OutSymbol=0, OutLast=0, InReady=0, Busy=0, EncState=0, bit counter=0, FSM=IDLE.
- Encoding:
  - vec = {b, EncState}, where b is the bit being encoded and is placed at vec[K-1].
  - c0 = XOR-reduce(vec & G0); c1 = XOR-reduce(vec & G1).
  - On encode, EncState <= vec[K-1:1].
- Output slot: "free" = ~OutValid | OutReady. An encode loads OutSymbol/OutLast and sets OutValid in the same edge (latency 1 cycle from input handshake to OutValid).
- Holding: while OutValid=1 and OutReady=0, OutSymbol, OutLast and EncState are held stable.
- Clearing: OutValid clears on an OutReady handshake only when no new encode happens that cycle.
- FSM IDLE:
  - InReady=0.
  - Start=1 -> clear EncState and counter, go to DATA.
  - Start is ignored in every other state.
- FSM DATA:
  - InReady = free.
  - An encode happens on InValid & InReady; counter increments.
  - On the encode where counter == FRAME_LEN-1: counter <= 0, go to TAIL.
- FSM TAIL:
  - InReady=0; InValid and InBit are ignored.
  - Whenever free, encode b=0; counter increments.
  - On the encode where counter == K-2: OutLast=1 with that symbol, go to IDLE.
  - EncState is 0 after the last tail encode.
- Back-to-back frames: Start in the IDLE cycle right after the tail may be accepted while the last symbol is still pending. The first DATA encode waits for the slot to be free; OutLast stays attached only to its symbol.
- Totals: exactly FRAME_LEN+K-1 symbols per frame; exactly one OutLast per frame.
- Reset mid-frame: all state returns to reset values immediately. The partial frame is discarded; no OutLast is emitted.
- Throughput: one symbol per cycle when OutReady is held at 1 and InValid is held at 1.

Test Plan:
- Impulse, FRAME_LEN=1, bit 1, OutReady=1:
  - 9 symbols 11,10,11,11,01,10,00,10,11.
  - OutLast only on the 9th symbol; EncState ends 0.
- All-zero frame, FRAME_LEN=16:
  - 24 symbols, all 00.
  - EncState stays 0; OutLast on symbol 24; InReady high for exactly 16 handshakes.
- Backpressure, random 64-bit frame, OutReady toggled randomly:
  - Symbol stream identical to a golden model; no drops or duplicates.
  - OutSymbol stable while OutValid=1 and OutReady=0.
  - InReady=0 whenever the slot is not free.
- Start pulsed during DATA and TAIL: ignored; symbol count and OutLast position unchanged.
- Reset asserted after 5 data bits:
  - Next cycle OutValid=0, Busy=0, EncState=0.
  - A new frame encodes exactly as from a fresh reset.
- Two frames back-to-back, Start in the IDLE cycle after the tail:
  - 2*(FRAME_LEN+8) symbols; exactly two OutLast pulses.
  - Decoder loopback recovers both frames error-free.
